a2d_spi_model: RTL and testbench

//  Synthesizable, parametrised model of a multi-channel SPI A2D (ADC128S-style) used as the slide-pot source in

---
 rtl/a2d_spi_model.sv | 136 +++++++++++++
 tb/tb_a2d_spi_model.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_spi_model.sv
// Parametrised SPI A2D slave model (ADC128S-style): returns a static or ramping value per channel,
// with the next frame's channel address taken from MOSI bits [13:11].
module a2d_spi_model #(
  parameter int NUM_CH    = 8,
  parameter int RES       = 12,
  parameter int RAMP_STEP = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SS_n,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [NUM_CH*RES-1:0] ch_val_in,
  input  logic [NUM_CH-1:0]     ramp_en,
  output logic                  conv_done,
  output logic [2:0]            conv_ch,
  output logic                  frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [RES-1:0] STEP = RES'(RAMP_STEP);

  state_t           state, state_nxt;
  logic [2:0]       ss_q, sclk_q;
  logic [1:0]       mosi_q;
  logic             ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [15:0]      tx_sr;
  logic [12:0]      rx_sr;
  logic [4:0]       bit_cnt;
  logic [2:0]       cur_ch;
  logic             ramp_hit;
  logic [RES-1:0]   ramp [NUM_CH];
  logic [15:0]      sel_val;
  logic             sel_ramp;
  logic             frame_load, shift_in, shift_out, frame_complete, frame_abort;

  // NOTE: every flop uses <= so all stages sample the pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign ss_fall   =  ss_q[2]   & ~ss_q[1];
  assign ss_rise   = ~ss_q[2]   &  ss_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];

  // NOTE: defaults assigned before the loop, so no path through this block leaves a variable unassigned (no latch).
  always_comb begin
    sel_val  = '0;
    sel_ramp = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_ch == 3'(k)) begin
        sel_ramp            = ramp_en[k];
        sel_val[RES-1:0]    = ramp_en[k] ? ramp[k] : ch_val_in[k*RES +: RES];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = SHIFT;
      SHIFT:   if (frame_complete) state_nxt = DONE;
               else if (ss_rise)   state_nxt = IDLE;
      DONE:    if (ss_q[1]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A completing 16th rise wins over a coincident SS_n rise.
  always_comb begin
    frame_load     = (state == IDLE) && ss_fall;
    shift_in       = (state == SHIFT) && sclk_rise;
    frame_complete = shift_in && (bit_cnt == 5'd15);
    frame_abort    = (state == SHIFT) && ss_rise && !frame_complete;
    shift_out      = (state == SHIFT) && sclk_fall && (bit_cnt != 5'd0);
  end

  assign MISO = (state != IDLE) && tx_sr[15];

  // NOTE: the ramp array sits in the reset branch because a reset must return every channel to a zero ramp.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      cur_ch    <= '0;
      ramp_hit  <= 1'b0;
      conv_done <= 1'b0;
      conv_ch   <= '0;
      frame_err <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) ramp[k] <= '0;
    end else begin
      conv_done <= frame_complete;
      frame_err <= frame_abort;
      if (frame_load) begin
        tx_sr    <= sel_val;
        bit_cnt  <= '0;
        ramp_hit <= sel_ramp;
      end
      if (shift_in) begin
        rx_sr   <= {rx_sr[11:0], MOSI_sync()};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (shift_out) tx_sr <= {tx_sr[14:0], 1'b0};
      // Only the 13 most recent bits are kept: bits [12:10] become word bits [13:11] on the 16th rise.
      if (frame_complete) begin
        cur_ch  <= rx_sr[12:10];
        conv_ch <= cur_ch;
        for (int k = 0; k < NUM_CH; k++) begin
          if (ramp_hit && cur_ch == 3'(k)) ramp[k] <= ramp[k] + STEP;
        end
      end
    end
  end

  function automatic logic MOSI_sync();
    return mosi_q[1];
  endfunction

endmodule

// File: tb/tb_a2d_spi_model.sv
// Directed bench for a2d_spi_model: a default 8ch/12b instance and a 5ch/10b instance, checked
// against a frame-level model of channel address, ramp registers and pulse counts.
module tb_a2d_spi_model;

  localparam int H = 50;

  logic        clk;
  logic        rst;
  logic        ss_n_a, ss_n_b, sclk, mosi;
  logic        miso_a, miso_b;
  logic [95:0] ch_val_a;
  logic [49:0] ch_val_b;
  logic [7:0]  ramp_en_a;
  logic [4:0]  ramp_en_b;
  logic        conv_done_a, conv_done_b, frame_err_a, frame_err_b;
  logic [2:0]  conv_ch_a, conv_ch_b;

  int vectors = 0;
  int miscompares = 0;

  int          mdl_ch   [2];
  logic [15:0] mdl_ramp [2][8];
  int          mdl_nch  [2] = '{8, 5};
  int          mdl_res  [2] = '{12, 10};

  int          done_cnt [2];
  int          err_cnt  [2];
  logic [2:0]  exp_ch   [2];
  int          ss_hi    [2];
  logic        prev_done [2];

  a2d_spi_model u_dut_a (
    .clk(clk), .rst(rst), .SS_n(ss_n_a), .SCLK(sclk), .MOSI(mosi), .MISO(miso_a),
    .ch_val_in(ch_val_a), .ramp_en(ramp_en_a), .conv_done(conv_done_a),
    .conv_ch(conv_ch_a), .frame_err(frame_err_a)
  );

  a2d_spi_model #(.NUM_CH(5), .RES(10), .RAMP_STEP(16)) u_dut_b (
    .clk(clk), .rst(rst), .SS_n(ss_n_b), .SCLK(sclk), .MOSI(mosi), .MISO(miso_b),
    .ch_val_in(ch_val_b), .ramp_en(ramp_en_b), .conv_done(conv_done_b),
    .conv_ch(conv_ch_b), .frame_err(frame_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit ramp_on(input int s, input int ch);
    if (ch >= mdl_nch[s]) return 1'b0;
    return (s == 1) ? ramp_en_b[ch] : ramp_en_a[ch];
  endfunction

  function automatic logic [15:0] model_val(input int s);
    int ch;
    ch = mdl_ch[s];
    if (ch >= mdl_nch[s]) return 16'h0000;
    if (ramp_on(s, ch))   return mdl_ramp[s][ch];
    if (s == 1)           return {6'd0, ch_val_b[ch*10 +: 10]};
    return {4'd0, ch_val_a[ch*12 +: 12]};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mdl_ch[s] = 0;
      for (int k = 0; k < 8; k++) mdl_ramp[s][k] = 16'h0000;
    end
  endtask

  task automatic drive_ss(input int s, input logic v);
    if (s == 1) ss_n_b = v;
    else        ss_n_a = v;
  endtask

  // Pulse monitor: conv_ch on every conv_done, pulse width, and MISO quiet while SS_n is high.
  always @(negedge clk) begin
    if (!rst) begin
      if (conv_done_a) begin
        done_cnt[0]++;
        check("conv_ch_a", {29'd0, conv_ch_a}, {29'd0, exp_ch[0]});
        check("conv_done_a width", {31'd0, prev_done[0]}, 32'd0);
        check("done_err overlap a", {31'd0, frame_err_a}, 32'd0);
      end
      if (frame_err_a) err_cnt[0]++;
      if (conv_done_b) begin
        done_cnt[1]++;
        check("conv_ch_b", {29'd0, conv_ch_b}, {29'd0, exp_ch[1]});
        check("conv_done_b width", {31'd0, prev_done[1]}, 32'd0);
        check("done_err overlap b", {31'd0, frame_err_b}, 32'd0);
      end
      if (frame_err_b) err_cnt[1]++;
      ss_hi[0] = ss_n_a ? ss_hi[0] + 1 : 0;
      ss_hi[1] = ss_n_b ? ss_hi[1] + 1 : 0;
      if (ss_hi[0] > 5) check("miso_a idle", {31'd0, miso_a}, 32'd0);
      if (ss_hi[1] > 5) check("miso_b idle", {31'd0, miso_b}, 32'd0);
    end
    prev_done[0] = conv_done_a;
    prev_done[1] = conv_done_b;
  end

  // One SPI frame of nbits clocks (SCLK idles high, MOSI changes on fall, MISO sampled at rise).
  task automatic frame(input int s, input logic [15:0] mw, input int nbits, input bit sim_end,
                       output logic [15:0] rx);
    logic [15:0] exp, mask;
    bit          rflag, complete;
    int          ch;
    ch        = mdl_ch[s];
    exp       = model_val(s);
    rflag     = ramp_on(s, ch);
    exp_ch[s] = 3'(ch);
    done_cnt[s] = 0;
    err_cnt[s]  = 0;
    rx = '0;
    @(posedge clk); #2;
    drive_ss(s, 1'b0);
    #H;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = mw[15-i];
      #H;
      rx[15-i] = (s == 1) ? miso_b : miso_a;
      sclk = 1'b1;
      if (sim_end && i == 15) drive_ss(s, 1'b1);
      #H;
    end
    drive_ss(s, 1'b1);
    mosi = 1'b0;
    #(3*H);
    complete = (nbits == 16);
    mask = ~(16'hFFFF >> nbits);
    check($sformatf("miso word dut%0d ch%0d", s, ch), {16'd0, rx & mask}, {16'd0, exp & mask});
    check($sformatf("conv_done count dut%0d", s), done_cnt[s], {31'd0, complete});
    check($sformatf("frame_err count dut%0d", s), err_cnt[s], {31'd0, !complete});
    if (complete) begin
      mdl_ch[s] = int'(mw[13:11]);
      if (rflag) mdl_ramp[s][ch] = (mdl_ramp[s][ch] + 16'd16) & 16'((1 << mdl_res[s]) - 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rx;
    logic [15:0] pre;
    rst = 1'b1; ss_n_a = 1'b1; ss_n_b = 1'b1; sclk = 1'b1; mosi = 1'b0;
    ch_val_a = {12'h987, 12'h654, 12'h321, 12'hFED, 12'h789, 12'h456, 12'h123, 12'hABC};
    ch_val_b = {10'h3FF, 10'h30F, 10'h0F0, 10'h2AA, 10'h155};
    ramp_en_a = '0; ramp_en_b = '0;
    for (int s = 0; s < 2; s++) begin
      done_cnt[s] = 0; err_cnt[s] = 0; exp_ch[s] = '0; ss_hi[s] = 0; prev_done[s] = 1'b0;
    end
    model_reset();

    repeat (5) @(posedge clk);
    #1;
    check("reset miso_a", {31'd0, miso_a}, 32'd0);
    check("reset conv_done_a", {31'd0, conv_done_a}, 32'd0);
    check("reset conv_ch_a", {29'd0, conv_ch_a}, 32'd0);
    check("reset frame_err_a", {31'd0, frame_err_a}, 32'd0);
    check("reset miso_b", {31'd0, miso_b}, 32'd0);
    check("reset conv_done_b", {31'd0, conv_done_b}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    frame(0, 16'h0800, 16, 1'b0, rx);
    check("t1 ch0 literal", {16'd0, rx}, 32'h0ABC);
    frame(0, 16'h0000, 16, 1'b0, rx);
    check("t2 ch1 literal", {16'd0, rx}, 32'h0123);

    ramp_en_a[2] = 1'b1;
    frame(0, 16'h1000, 16, 1'b0, rx);
    check("t3 lead-in ch0", {16'd0, rx}, 32'h0ABC);
    for (int i = 0; i < 300; i++) begin
      frame(0, 16'h1000, 16, 1'b0, rx);
      if (i == 0)   check("t3 ramp first", {16'd0, rx}, 32'h0000);
      if (i == 1)   check("t3 ramp step", {16'd0, rx}, 32'h0010);
      if (i == 255) check("t3 ramp top", {16'd0, rx}, 32'h0FF0);
      if (i == 256) check("t3 ramp wrap", {16'd0, rx}, 32'h0000);
    end

    frame(0, 16'h0000, 9, 1'b0, rx);
    frame(0, 16'h0000, 16, 1'b0, rx);
    check("t4 after abort", {16'd0, rx}, 32'h02C0);
    frame(0, 16'h1000, 16, 1'b1, rx);
    check("t4 simultaneous end", {16'd0, rx}, 32'h0ABC);
    frame(0, 16'h0000, 16, 1'b0, rx);
    check("t4 addr after simultaneous end", {16'd0, rx}, 32'h02D0);

    frame(1, 16'h3000, 16, 1'b0, rx);
    check("t5 b ch0", {16'd0, rx}, 32'h0155);
    frame(1, 16'h2000, 16, 1'b0, rx);
    check("t5 b addr 6", {16'd0, rx}, 32'h0000);
    frame(1, 16'h0000, 16, 1'b0, rx);
    check("t5 b ch4", {16'd0, rx}, 32'h03FF);

    frame(0, 16'h0800, 16, 1'b0, rx);
    pre = model_val(0);
    @(posedge clk); #2;
    ss_n_a = 1'b0;
    #H;
    for (int i = 0; i < 7; i++) begin
      sclk = 1'b0; mosi = 1'b0; #H;
      sclk = 1'b1; #H;
    end
    sclk = 1'b0;
    #H;
    check("t6 pre-reset miso bit8", {31'd0, miso_a}, {31'd0, pre[8]});
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6 miso at reset", {31'd0, miso_a}, 32'd0);
    ss_n_a = 1'b1; sclk = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    frame(0, 16'h1000, 16, 1'b0, rx);
    check("t6 fresh frame ch0", {16'd0, rx}, 32'h0ABC);
    frame(0, 16'h0000, 16, 1'b0, rx);
    check("t6 ramp cleared", {16'd0, rx}, 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
